// File: rtl/keypad_scan_ctrl.sv
// Debounced matrix-keypad scanner: one-hot column strobes, one event per physical press.
// Optional macro KEYPAD_RELEASE_EVT_EN adds a key_rel pulse when a release is accepted.
module keypad_scan_ctrl #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SCAN_DIV       = 1200,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_ROWS-1:0]         row_in,
    output logic [NUM_COLS-1:0]         col_out,
    output logic                        key_valid,
    output logic [$clog2(NUM_ROWS)-1:0] key_row,
    output logic [$clog2(NUM_COLS)-1:0] key_col,
`ifdef KEYPAD_RELEASE_EVT_EN
    output logic                        key_rel,
`endif
    output logic                        key_held
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t              state;
    logic [NUM_ROWS-1:0] row_m, row_s;
    logic [TW-1:0]       tick_cnt;
    logic [DW-1:0]       db_cnt;
    logic [CW-1:0]       col_idx, col_next, cand_col;
    logic [RW-1:0]       cand_row, hit_row;
    logic                hit_any, cand_hit, tick;
    logic [DW-1:0]       db_next;

    assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
    assign cand_hit = row_s[cand_row];
    assign db_next  = db_cnt + 1'b1;

    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        hit_any = 1'b0;
        hit_row = '0;
        // Walk downwards so the lowest set row is the one left standing.
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_s[r]) begin
                hit_any = 1'b1;
                hit_row = RW'(r);
            end
        end
        col_next = (col_idx == CW'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_m     <= '0;
            row_s     <= '0;
            tick_cnt  <= '0;
            db_cnt    <= '0;
            col_idx   <= '0;
            col_out   <= NUM_COLS'(1);
            cand_row  <= '0;
            cand_col  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_row   <= '0;
            key_col   <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            key_rel   <= 1'b0;
`endif
        end else begin
            row_m     <= row_in;
            row_s     <= row_m;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            key_valid <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
            key_rel   <= 1'b0;
`endif
            case (state)
                SCAN: if (tick) begin
                    if (hit_any) begin
                        cand_row <= hit_row;
                        cand_col <= col_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            state     <= HELD;
                            key_row   <= hit_row;
                            key_col   <= col_idx;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            state  <= DEB_PRESS;
                            db_cnt <= DW'(1);
                        end
                    end else begin
                        col_idx <= col_next;
                        col_out <= NUM_COLS'(1) << col_next;
                    end
                end
                DEB_PRESS: if (tick) begin
                    if (!cand_hit) begin
                        state   <= SCAN;
                        col_idx <= col_next;
                        col_out <= NUM_COLS'(1) << col_next;
                    end else if (db_next == DW'(DEBOUNCE_TICKS)) begin
                        state     <= HELD;
                        key_row   <= cand_row;
                        key_col   <= cand_col;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                HELD: if (tick && !cand_hit) begin
                    if (DEBOUNCE_TICKS == 1) begin
                        state    <= SCAN;
                        key_held <= 1'b0;
                        col_idx  <= col_next;
                        col_out  <= NUM_COLS'(1) << col_next;
`ifdef KEYPAD_RELEASE_EVT_EN
                        key_rel  <= 1'b1;
`endif
                    end else begin
                        state  <= DEB_REL;
                        db_cnt <= DW'(1);
                    end
                end
                DEB_REL: if (tick) begin
                    if (cand_hit) begin
                        state <= HELD;
                    end else if (db_next == DW'(DEBOUNCE_TICKS)) begin
                        state    <= SCAN;
                        key_held <= 1'b0;
                        col_idx  <= col_next;
                        col_out  <= NUM_COLS'(1) << col_next;
`ifdef KEYPAD_RELEASE_EVT_EN
                        key_rel  <= 1'b1;
`endif
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                default: begin
                    state    <= SCAN;
                    key_held <= 1'b0;
                    col_idx  <= '0;
                    col_out  <= NUM_COLS'(1);
                end
            endcase
        end
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad scanner. Drives one-hot column strobes, samples synchronised row inputs, debounces both press and release, and reports one key event per physical press as a row/column index with a single-cycle valid pulse. Sits between the keypad pins and the key-decode/display logic, and replaces the fixed 4x4 undebounced scanner.

Parameters:
NUM_ROWS, 4, number of row inputs (2..8)
NUM_COLS, 4, number of column strobes (2..8)
SCAN_DIV, 1200, clk cycles per scan tick; minimum 4
DEBOUNCE_TICKS, 3, consecutive agreeing ticks needed to accept a press or a release; minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
row_in  in  NUM_ROWS  raw keypad rows; 1 = pressed on the strobed column; asynchronous to clk
col_out  out  NUM_COLS  one-hot column strobe
key_valid  out  1  one-clk pulse when a press is accepted
key_row  out  $clog2(NUM_ROWS)  row index of the accepted key
key_col  out  $clog2(NUM_COLS)  column index of the accepted key
key_held  out  1  high from acceptance until release is accepted

Behaviour:
- Reset (async assert, sync deassert use):
  - state = SCAN, column index = 0, col_out = 1 (column 0)
  - tick and debounce counters = 0; synchroniser flops = 0
  - key_valid = 0, key_held = 0, key_row = 0, key_col = 0
- row_in passes through a 2-flop synchroniser (row_s). Only row_s is used.
- Tick counter:
  - counts 0..SCAN_DIV-1, then wraps
  - tick = 1 for one cycle when count == SCAN_DIV-1
  - free-running in every state
- Column change happens only on a tick. SCAN_DIV >= 4 guarantees row_s reflects the current column before the next tick.
- SCAN, on tick:
  - any row_s bit set: latch lowest set row index into cand_row and current column into cand_col; db_cnt = 1 if DEBOUNCE_TICKS > 1, otherwise accept immediately (see DEB_PRESS accept). Go to DEB_PRESS; column does not advance.
  - no row_s bit set: column advances, wrapping NUM_COLS-1 -> 0.
- DEB_PRESS (column frozen), on tick:
  - row_s[cand_row] = 1: db_cnt++. On reaching DEBOUNCE_TICKS, go to HELD; key_row/key_col <= cand; key_valid = 1 in the following clk cycle only; key_held = 1.
  - row_s[cand_row] = 0: go to SCAN and advance column; no event.
- HELD (column frozen), on tick: row_s[cand_row] = 0 -> DEB_REL, db_cnt = 1. Other rows are ignored; first key wins.
- DEB_REL, on tick:
  - row_s[cand_row] = 0: db_cnt++. On reaching DEBOUNCE_TICKS, key_held = 0, go to SCAN and advance column.
  - row_s[cand_row] = 1: back to HELD; no new key_valid.
- key_row/key_col hold their last accepted value until the next acceptance.
- Simultaneous keys on the same column: lowest row index wins. Keys on other columns are not seen until return to SCAN.
- Outputs are registered, and state is never illegal. Any unused encoding recovers to SCAN with column 0.
- Reset mid-operation aborts immediately: no pulse, key_held clears.

Optional Feature:
KEYPAD_RELEASE_EVT_EN
- Defined: adds output port key_rel (1 bit). It pulses for one clk cycle when a release is accepted, with key_row/key_col still showing the released key.
- Undefined: port absent; release is visible only as the key_held falling edge.

Test Plan:
All cases use NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=4, DEBOUNCE_TICKS=3.
- Reset, no keys: col_out cycles 0001->0010->0100->1000->0001, changing every 4 clk. key_valid never asserts; key_held = 0.
- Clean press of row 2 when col 1 strobed, held 10 ticks: exactly one key_valid pulse, key_row = 2, key_col = 1, col_out frozen at 0010 while held. After release plus 3 ticks, key_held = 0 and scanning resumes at col 2.
- Bounce: row 0 on col 0 high for 1 tick, then low: no key_valid and scan continues. Then a stable press gives exactly one pulse with row 0, col 0.
- Release bounce: while held, row drops for 1 tick and returns: key_held stays 1 and no second pulse. A stable 3-tick release then clears key_held.
- Rows 1 and 3 pressed together on col 2: key_row = 1. A second key on col 3 pressed during HELD produces no event.
- Assert rst during DEB_PRESS: col_out = 0001, key_held = 0, no pulse. With KEYPAD_RELEASE_EVT_EN defined, key_rel pulses once at the end of the release-debounce case.
